// File: rtl/msx_audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msx_audio_pkg                                                |
// | Description : Shared types, constants and the saturating clamp helper for  |
// |               the MSX N-channel audio mixer.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package msx_audio_pkg;

    // Gains are unsigned Q1.3: 8 is unity, 15 is 1.875, 0 mutes the channel.
    localparam int GAIN_W    = 4;
    localparam int GAIN_FRAC = 3;

    // Mixer sequencing states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        SAT  = 2'd2
    } mix_state_t;

    // Clamp a signed value into the signed range of 'width' bits.
    // Callers sign-extend into 64 bits and truncate the result back down.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                     input int                 width);
        logic signed [63:0] w_max;
        logic signed [63:0] w_min;
        w_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        w_min = -(64'sd1 <<< (width - 1));
        if (value > w_max) begin
            return w_max;
        end else if (value < w_min) begin
            return w_min;
        end else begin
            return value;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_dc_block.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_dc_block                                               |
// | Description : Optional first-order DC blocker after the mixer saturation   |
// |               stage. Build macro MIX_DCBLOCK_EN enables the filter; without|
// |               it the block is a plain wire-through with no registers.      |
// |               y = x - x_prev + y_prev - (y_prev >>> 8), 2 guard bits, then |
// |               saturated back to W bits.                                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module audio_dc_block
    import msx_audio_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in,
    output logic         out_valid,
    output logic [W-1:0] out
);

`ifdef MIX_DCBLOCK_EN
    localparam int c_GW = W + 2;

    logic signed [W-1:0]    r_x_prev;
    logic signed [W-1:0]    r_y_prev;
    logic [W-1:0]           r_out;
    logic                   r_out_valid;
    logic signed [c_GW-1:0] w_sum;
    logic signed [W-1:0]    w_y;

    // Filter arithmetic in the widened domain, then clamp to the output range.
    always_comb begin
        w_sum = c_GW'($signed(in)) - c_GW'(r_x_prev) + c_GW'(r_y_prev)
              - c_GW'(r_y_prev >>> 8);
        w_y   = W'(sat_clamp(64'(w_sum), W));
    end

    // History and output register advance only on an incoming sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x_prev    <= '0;
            r_y_prev    <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_x_prev <= $signed(in);
                r_y_prev <= w_y;
                r_out    <= w_y;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
`else
    // Clock and reset have no job without the filter.
    logic w_unused;
    assign w_unused  = &{1'b0, clk, reset};
    assign out       = in;
    assign out_valid = in_valid;
`endif

endmodule
`default_nettype wire

// File: rtl/audio_mixer_n.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : audio_mixer_n                                                |
// | Description : N-channel time-multiplexed audio mixer. Snapshots inputs on  |
// |               ce_sample, accumulates ext(ch_i) * gain_i one channel per    |
// |               cycle, scales by 1/8, saturates to signed OUT_W and pulses   |
// |               audio_valid. Optional macro MIX_DCBLOCK_EN inserts a DC      |
// |               blocker stage (one extra cycle of latency).                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module audio_mixer_n
    import msx_audio_pkg::*;
#(
    parameter int              N_CH        = 4,
    parameter int              IN_W        = 16,
    parameter logic [N_CH-1:0] SIGNED_MASK = 4'b0001,
    parameter int              OUT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ce_sample,
    input  logic [N_CH*IN_W-1:0]   ch_in,
    input  logic [N_CH*GAIN_W-1:0] ch_gain,
    output logic [OUT_W-1:0]       audio,
    output logic                   audio_valid,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int IDX_W = $clog2(N_CH);
    localparam int ACC_W = IN_W + 1 + GAIN_W + IDX_W;

    mix_state_t              r_state;
    mix_state_t              w_state_next;
    logic [IDX_W-1:0]        r_idx;
    logic signed [ACC_W-1:0] r_acc;
    logic [N_CH*IN_W-1:0]    r_snap_in;
    logic [N_CH*GAIN_W-1:0]  r_snap_gain;
    logic [OUT_W-1:0]        r_audio;
    logic                    r_valid;
    logic                    r_overrun;

    logic [IN_W-1:0]         w_sample;
    logic [GAIN_W-1:0]       w_gain;
    logic signed [IN_W:0]    w_ext;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_acc_sum;
    logic signed [ACC_W-1:0] w_scaled;
    logic [OUT_W-1:0]        w_clamped;
    logic                    w_last;
    logic                    w_ready;
    logic                    w_pipe_busy;
    logic                    w_start;
    logic                    w_step;
    logic                    w_finish;
    logic                    w_drop;
    logic [OUT_W-1:0]        w_dc_out;
    logic                    w_dc_valid;

    // Single shared multiplier: pick the current channel, extend it, scale by its gain.
    always_comb begin
        w_sample  = r_snap_in[r_idx*IN_W +: IN_W];
        w_gain    = r_snap_gain[r_idx*GAIN_W +: GAIN_W];
        w_ext     = SIGNED_MASK[r_idx] ? {w_sample[IN_W-1], w_sample} : {1'b0, w_sample};
        w_term    = ACC_W'(w_ext) * $signed(ACC_W'(w_gain));
        w_acc_sum = r_acc + w_term;
        w_scaled  = w_acc_sum >>> GAIN_FRAC;
        w_clamped = OUT_W'(sat_clamp(64'(w_scaled), OUT_W));
        w_last    = (r_idx == IDX_W'(N_CH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one MAC cycle per channel, then one SAT/valid cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ce_sample && w_ready) w_state_next = MAC;
            MAC:     if (w_last)               w_state_next = SAT;
            SAT:                               w_state_next = IDLE;
            default:                           w_state_next = IDLE;
        endcase
    end

    // Control decode. The final accumulate and the clamp share one edge so the
    // registered sample is already valid during the SAT cycle.
    always_comb begin
        w_ready  = (r_state == IDLE) && !w_pipe_busy;
        w_start  = ce_sample && w_ready;
        w_drop   = ce_sample && !w_ready;
        w_step   = (r_state == MAC);
        w_finish = (r_state == MAC) && w_last;
    end

    // Snapshot, accumulate and output sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_snap_in   <= '0;
            r_snap_gain <= '0;
            r_audio     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_valid <= w_finish;
            if (w_start) begin
                r_snap_in   <= ch_in;
                r_snap_gain <= ch_gain;
                r_acc       <= '0;
                r_idx       <= '0;
            end else if (w_step) begin
                r_acc <= w_acc_sum;
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_finish) begin
                r_audio <= w_clamped;
            end
        end
    end

    // Sticky overrun flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    audio_dc_block #(
        .W (OUT_W)
    ) u_dc_block (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (r_valid),
        .in        (r_audio),
        .out_valid (w_dc_valid),
        .out       (w_dc_out)
    );

`ifdef MIX_DCBLOCK_EN
    // The filter's output cycle still belongs to the previous sample.
    assign w_pipe_busy = w_dc_valid;
`else
    assign w_pipe_busy = 1'b0;
`endif

    assign audio       = w_dc_out;
    assign audio_valid = w_dc_valid;
    assign overrun     = r_overrun;

endmodule
`default_nettype wire
